// File: rtl/opfetch_pkg.sv
// Shared widths for the operand fetch stage and its pending-write scoreboard.
// Optional same-cycle writeback bypass is enabled by defining OPFETCH_BYPASS_EN.
package opfetch_pkg;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int NREGS  = 1 << ADDR_W;
endpackage

// File: rtl/reg_scoreboard.sv
// One pending bit per architectural register. A set and a clear of the same
// entry in the same cycle leaves the entry pending.
module reg_scoreboard
  import opfetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_s,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic [ADDR_W-1:0] rd_addr_d,
  output logic              pend_a,
  output logic              pend_b,
  output logic              pend_d
);

  logic [NREGS-1:0] sb_reg;
  logic [NREGS-1:0] sb_next;

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_entry
      assign sb_next[gi] = (set_en && (set_addr == ADDR_W'(gi))) ? 1'b1 :
                           (clr_en && (clr_addr == ADDR_W'(gi))) ? 1'b0 :
                           sb_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      sb_reg <= '0;
    end else begin
      sb_reg <= sb_next;
    end
  end

  // Reads see the pre-edge state, so a writeback landing this cycle still stalls.
  assign pend_a = sb_reg[rd_addr_a];
  assign pend_b = sb_reg[rd_addr_b];
  assign pend_d = sb_reg[rd_addr_d];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: regfile read addressing, RAW/WAW hazard stall, 1-entry output register.
// Define OPFETCH_BYPASS_EN to forward same-cycle writeback data instead of stalling on it.
module operand_fetch
  import opfetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_s,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic              in_use_rs,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic              in_use_rt,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_rd_we,
  output logic [ADDR_W-1:0] raddr_1,
  input  logic [DATA_W-1:0] rdata_1,
  output logic [ADDR_W-1:0] raddr_2,
  input  logic [DATA_W-1:0] rdata_2,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_rd_we
);

  logic              pend_a, pend_b, pend_d;
  logic              wb_clash, hazard, fire;
  logic [DATA_W-1:0] op_a_next, op_b_next;
  logic              out_valid_reg;
  logic [DATA_W-1:0] op_a_reg, op_b_reg;
  logic [ADDR_W-1:0] out_rd_reg;
  logic              out_rd_we_reg;

  assign raddr_1 = in_rs;
  assign raddr_2 = in_rt;

  reg_scoreboard u_sb (
    .clk       (clk),
    .rst_s     (rst_s),
    .set_en    (fire && in_rd_we),
    .set_addr  (in_rd),
    .clr_en    (wb_we),
    .clr_addr  (wb_waddr),
    .rd_addr_a (in_rs),
    .rd_addr_b (in_rt),
    .rd_addr_d (in_rd),
    .pend_a    (pend_a),
    .pend_b    (pend_b),
    .pend_d    (pend_d)
  );

`ifdef OPFETCH_BYPASS_EN
  assign wb_clash  = 1'b0;
  assign op_a_next = (wb_we && (wb_waddr == in_rs)) ? wb_wdata : rdata_1;
  assign op_b_next = (wb_we && (wb_waddr == in_rt)) ? wb_wdata : rdata_2;
`else
  // Regfile read is combinational and sees the old value, so wait out the write edge.
  assign wb_clash  = wb_we && ((in_use_rs && (wb_waddr == in_rs)) ||
                               (in_use_rt && (wb_waddr == in_rt)));
  assign op_a_next = rdata_1;
  assign op_b_next = rdata_2;
  logic unused_wdata;
  assign unused_wdata = ^wb_wdata;
`endif

  assign hazard   = (in_use_rs && pend_a) || (in_use_rt && pend_b) ||
                    (in_rd_we && pend_d) || wb_clash;
  assign in_ready = (!out_valid_reg || out_ready) && !hazard;
  assign fire     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      out_valid_reg <= 1'b0;
      op_a_reg      <= '0;
      op_b_reg      <= '0;
      out_rd_reg    <= '0;
      out_rd_we_reg <= 1'b0;
    end else if (fire) begin
      out_valid_reg <= 1'b1;
      op_a_reg      <= op_a_next;
      op_b_reg      <= op_b_next;
      out_rd_reg    <= in_rd;
      out_rd_we_reg <= in_rd_we;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign op_a      = op_a_reg;
  assign op_b      = op_b_reg;
  assign out_rd    = out_rd_reg;
  assign out_rd_we = out_rd_we_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed hazard scenarios then randomized traffic against a
// register-level reference model (regfile array + pending set + output bundle).
module tb_operand_fetch;
  import opfetch_pkg::*;

  logic              clk = 1'b0;
  logic              rst_s;
  logic              in_valid, in_ready;
  logic [ADDR_W-1:0] in_rs, in_rt, in_rd;
  logic              in_use_rs, in_use_rt, in_rd_we;
  logic [ADDR_W-1:0] raddr_1, raddr_2;
  logic [DATA_W-1:0] rdata_1, rdata_2;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_waddr;
  logic [DATA_W-1:0] wb_wdata;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] op_a, op_b;
  logic [ADDR_W-1:0] out_rd;
  logic              out_rd_we;

  // Reference state
  logic [DATA_W-1:0] regs [NREGS];
  bit                pend [NREGS];
  bit                m_ov, m_we;
  logic [DATA_W-1:0] m_a, m_b;
  logic [ADDR_W-1:0] m_rd;
  bit                exp_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rdata_1 = regs[raddr_1];
  assign rdata_2 = regs[raddr_2];

  operand_fetch dut (
    .clk(clk), .rst_s(rst_s),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_use_rs(in_use_rs),
    .in_rt(in_rt), .in_use_rt(in_use_rt),
    .in_rd(in_rd), .in_rd_we(in_rd_we),
    .raddr_1(raddr_1), .rdata_1(rdata_1),
    .raddr_2(raddr_2), .rdata_2(rdata_2),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .op_a(op_a), .op_b(op_b),
    .out_rd(out_rd), .out_rd_we(out_rd_we)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                       input int rd, input bit we);
    in_valid  = v;
    in_rs     = ADDR_W'(rs);  in_use_rs = urs;
    in_rt     = ADDR_W'(rt);  in_use_rt = urt;
    in_rd     = ADDR_W'(rd);  in_rd_we  = we;
  endtask

  task automatic wb(input bit we, input int addr, input logic [31:0] data);
    wb_we = we; wb_waddr = ADDR_W'(addr); wb_wdata = data;
  endtask

  // Expected in_ready from the stall rules, checked with the read addresses.
  task automatic settle();
    bit haz;
    #1;
    haz = (in_use_rs && pend[in_rs]) || (in_use_rt && pend[in_rt]) || (in_rd_we && pend[in_rd]);
`ifndef OPFETCH_BYPASS_EN
    haz = haz || (wb_we && ((in_use_rs && wb_waddr == in_rs) || (in_use_rt && wb_waddr == in_rt)));
`endif
    exp_ready = (!m_ov || out_ready) && !haz;
    check("in_ready", in_ready, exp_ready);
    check("raddr_1", raddr_1, in_rs);
    check("raddr_2", raddr_2, in_rt);
  endtask

  // Advance one clock, then apply that edge's effects to the model and compare outputs.
  task automatic tick();
    bit fire;
    @(negedge clk);
    fire = in_valid && exp_ready;
    if (fire) begin
      m_ov = 1'b1;
`ifdef OPFETCH_BYPASS_EN
      m_a = (wb_we && wb_waddr == in_rs) ? wb_wdata : regs[in_rs];
      m_b = (wb_we && wb_waddr == in_rt) ? wb_wdata : regs[in_rt];
`else
      m_a = regs[in_rs];
      m_b = regs[in_rt];
`endif
      m_rd = in_rd;
      m_we = in_rd_we;
    end else if (m_ov && out_ready) begin
      m_ov = 1'b0;
    end
    if (wb_we) pend[wb_waddr] = 1'b0;
    if (fire && in_rd_we) pend[in_rd] = 1'b1;
    if (wb_we) regs[wb_waddr] = wb_wdata;
    check("out_valid", out_valid, m_ov);
    check("op_a", op_a, m_a);
    check("op_b", op_b, m_b);
    check("out_rd", out_rd, m_rd);
    check("out_rd_we", out_rd_we, m_we);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) pend[i] = 1'b0;
    m_ov = 1'b0; m_we = 1'b0; m_a = '0; m_b = '0; m_rd = '0;
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
    regs[2] = 32'd2;
    regs[3] = 32'd3;
    model_reset();
    rst_s = 1'b0;
    issue(0, 0, 0, 0, 0, 0, 0);
    wb(0, 0, 0);
    out_ready = 1'b1;

    // 1: reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_op_a", op_a, 0);
    check("rst_out_rd_we", out_rd_we, 0);
    rst_s = 1'b1;
    settle();
    check("rst_in_ready", in_ready, 1);
    tick();

    // 2: basic issue
    issue(1, 2, 1, 3, 1, 5, 1);
    settle();
    tick();
    check("basic_op_a", op_a, 2);
    check("basic_op_b", op_b, 3);
    check("basic_out_rd", out_rd, 5);

    // 3: RAW on r5, writeback releases it one edge later
    issue(1, 5, 1, 0, 0, 6, 0);
    settle();
    check("raw_stall", in_ready, 0);
    tick();
    wb(1, 5, 32'h55);
    settle();
    check("raw_stall_wb_cycle", in_ready, 0);
    tick();
    wb(0, 0, 0);
    settle();
    check("raw_release", in_ready, 1);
    tick();
    check("raw_op_a", op_a, 32'h55);

    // 4: writeback to a source in the issue cycle
    issue(1, 7, 1, 0, 0, 0, 0);
    wb(1, 7, 32'h77);
    settle();
`ifdef OPFETCH_BYPASS_EN
    check("byp_no_stall", in_ready, 1);
    tick();
    wb(0, 0, 0);
`else
    check("byp_stall", in_ready, 0);
    tick();
    wb(0, 0, 0);
    settle();
    check("byp_release", in_ready, 1);
    tick();
`endif
    check("byp_op_a", op_a, 32'h77);

    // 5: backpressure holds the bundle
    issue(1, 2, 1, 3, 1, 10, 0);
    settle();
    tick();
    out_ready = 1'b0;
    issue(1, 3, 1, 2, 1, 11, 0);
    for (int i = 0; i < 2; i++) begin
      settle();
      check("bp_in_ready", in_ready, 0);
      tick();
      check("bp_hold_a", op_a, 2);
      check("bp_hold_b", op_b, 3);
    end
    out_ready = 1'b1;
    settle();
    check("bp_release", in_ready, 1);
    tick();
    check("bp_next_a", op_a, 3);
    check("bp_next_b", op_b, 2);

    // 6: WAW stall, then set wins over an untracked writeback to the same register
    issue(1, 0, 0, 0, 0, 4, 1);
    settle();
    tick();
    settle();
    check("waw_stall", in_ready, 0);
    tick();
    issue(1, 0, 0, 0, 0, 9, 1);
    wb(1, 9, 32'h99);
    settle();
    check("setwin_issue", in_ready, 1);
    tick();
    wb(0, 0, 0);
    issue(1, 9, 1, 0, 0, 0, 0);
    settle();
    check("setwin_pending", in_ready, 0);
    tick();
    issue(0, 0, 0, 0, 0, 0, 0);
    wb(1, 4, 32'h44);
    settle();
    tick();
    wb(1, 9, 32'h9a);
    settle();
    tick();
    wb(0, 0, 0);

    // Randomized traffic with a reset in the middle
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        issue(1, 1, 1, 2, 1, 3, 1);
        settle();
        tick();
        out_ready = 1'b0;
        rst_s = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_op_a", op_a, 0);
        check("midrst_out_rd", out_rd, 0);
        model_reset();
        issue(0, 0, 0, 0, 0, 0, 0);
        wb(0, 0, 0);
        @(negedge clk);
        rst_s = 1'b1;
        issue(1, 3, 1, 3, 1, 3, 1);
        settle();
        check("midrst_in_ready", in_ready, 1);
        tick();
      end
      issue($urandom_range(0, 9) < 7, $urandom_range(0, 15), $urandom_range(0, 1),
            $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1));
      wb($urandom_range(0, 1), $urandom_range(0, 15), $urandom);
      out_ready = $urandom_range(0, 3) != 0;
      settle();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
